gdma_arb: RTL and testbench

GDMA_ARB -- requirements
Module: gdma_arb

---
 rtl/gdma_pkg.sv | 15 +
 rtl/gdma_rr_pick.sv | 30 +++
 rtl/gdma_arb.sv | 153 +++++++++++++++
 tb/tb_gdma_arb.sv | 423 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/gdma_pkg.sv
// Shared definitions for the GDMA request arbiter: default sizes and FSM encoding.
package gdma_pkg;

  localparam int NREQ = 8;
  localparam int AW   = 49;
  localparam int LW   = 32;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_GAP   = 2'd3
  } gdma_state_e;

endpackage

// File: rtl/gdma_rr_pick.sv
// Combinational round-robin picker: first set request after i_last, wrapping to 0.
module gdma_rr_pick
  import gdma_pkg::*;
#(
  parameter int NREQ = gdma_pkg::NREQ,
  parameter int IW   = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic [NREQ-1:0] i_req,
  input  logic [IW-1:0]   i_last,
  output logic [IW-1:0]   o_idx,
  output logic            o_any
);

  logic [IW-1:0] w_j;

  always_comb begin
    o_idx = '0;
    o_any = 1'b0;
    w_j   = '0;
    // k = NREQ lands back on i_last itself, so it has lowest priority
    for (int k = 1; k <= NREQ; k++) begin
      w_j = IW'((int'(i_last) + k) % NREQ);
      if (!o_any && i_req[w_j]) begin
        o_any = 1'b1;
        o_idx = w_j;
      end
    end
  end

endmodule

// File: rtl/gdma_arb.sv
// Arbitrates per-channel read/write start requests onto one shared DMA engine,
// one outstanding command at a time, with an optional idle gap after each job.
//
// state | meaning
// IDLE  | no job; grant round-robin winner when anything is pending
// ISSUE | cmd_valid high, fields frozen until cmd_ready
// WAIT  | command accepted, waiting for eng_done
// GAP   | throttle: speed_divider idle cycles before the next grant
module gdma_arb #(
  parameter int NREQ = gdma_pkg::NREQ,
  parameter int AW   = gdma_pkg::AW,
  parameter int LW   = gdma_pkg::LW
) (
  input  logic             gdma_clk,
  input  logic             gdma_rst_n,
  input  logic [NREQ-1:0]  req_start,
  input  logic [NREQ*AW-1:0] req_addr,
  input  logic [NREQ*LW-1:0] req_len,
  input  logic [31:0]      speed_divider,
  output logic             cmd_valid,
  input  logic             cmd_ready,
  output logic [2:0]       cmd_id,
  output logic [AW-1:0]    cmd_addr,
  output logic [LW-1:0]    cmd_len,
  input  logic             eng_done,
  output logic [NREQ-1:0]  req_done,
  output logic [NREQ-1:0]  pending,
  output logic             busy
);
  import gdma_pkg::*;

  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;

  gdma_state_e     r_state;
  logic [NREQ-1:0] r_start_q;
  logic [NREQ-1:0] r_pending;
  logic [NREQ-1:0] r_req_done;
  logic            r_armed;
  logic [IW-1:0]   r_last;
  logic [IW-1:0]   r_id;
  logic [AW-1:0]   r_addr;
  logic [LW-1:0]   r_len;
  logic            r_cmd_valid;
  logic [31:0]     r_gap_cnt;

  logic [NREQ-1:0] w_rise;
  logic [NREQ-1:0] w_gmask;
  logic [IW-1:0]   w_idx;
  logic            w_any;
  logic            w_grant;
  logic [AW-1:0]   w_sel_addr;
  logic [LW-1:0]   w_sel_len;

  gdma_rr_pick #(
    .NREQ (NREQ),
    .IW   (IW)
  ) u_rr_pick (
    .i_req  (r_pending),
    .i_last (r_last),
    .o_idx  (w_idx),
    .o_any  (w_any)
  );

  // The first cycle after reset only captures levels, so starts held high
  // through a reset do not look like fresh rising edges.
  assign w_rise     = r_armed ? (req_start & ~r_start_q) : '0;
  assign w_grant    = (r_state == ST_IDLE) && w_any;
  assign w_gmask    = w_grant ? ({{(NREQ-1){1'b0}}, 1'b1} << w_idx) : '0;
  assign w_sel_addr = req_addr[int'(w_idx)*AW +: AW];
  assign w_sel_len  = req_len[int'(w_idx)*LW +: LW];

  always_ff @(posedge gdma_clk or negedge gdma_rst_n) begin
    if (!gdma_rst_n) begin
      r_start_q <= '0;
      r_pending <= '0;
      r_armed   <= 1'b0;
    end else begin
      r_start_q <= req_start;
      r_armed   <= 1'b1;
      r_pending <= (r_pending & ~w_gmask) | w_rise;
    end
  end

  always_ff @(posedge gdma_clk or negedge gdma_rst_n) begin
    if (!gdma_rst_n) begin
      r_state     <= ST_IDLE;
      r_last      <= IW'(NREQ - 1);
      r_id        <= '0;
      r_addr      <= '0;
      r_len       <= '0;
      r_cmd_valid <= 1'b0;
      r_req_done  <= '0;
      r_gap_cnt   <= '0;
    end else begin
      r_req_done <= '0;
      case (r_state)
        ST_IDLE: begin
          if (w_any) begin
            r_last <= w_idx;
            r_id   <= w_idx;
            r_addr <= w_sel_addr;
            r_len  <= w_sel_len;
            if (w_sel_len == '0) begin
              r_req_done[w_idx] <= 1'b1;
              if (speed_divider != 32'd0) begin
                r_state   <= ST_GAP;
                r_gap_cnt <= speed_divider;
              end
            end else begin
              r_state     <= ST_ISSUE;
              r_cmd_valid <= 1'b1;
            end
          end
        end
        ST_ISSUE: begin
          if (cmd_ready) begin
            r_cmd_valid <= 1'b0;
            r_state     <= ST_WAIT;
          end
        end
        ST_WAIT: begin
          if (eng_done) begin
            r_req_done[r_id] <= 1'b1;
            if (speed_divider != 32'd0) begin
              r_state   <= ST_GAP;
              r_gap_cnt <= speed_divider;
            end else begin
              r_state <= ST_IDLE;
            end
          end
        end
        ST_GAP: begin
          if (r_gap_cnt <= 32'd1) begin
            r_state   <= ST_IDLE;
            r_gap_cnt <= '0;
          end else begin
            r_gap_cnt <= r_gap_cnt - 32'd1;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign cmd_valid = r_cmd_valid;
  assign cmd_id    = 3'(r_id);
  assign cmd_addr  = r_addr;
  assign cmd_len   = r_len;
  assign req_done  = r_req_done;
  assign pending   = r_pending;
  assign busy      = (r_state != ST_IDLE);

endmodule

// File: tb/tb_gdma_arb.sv
// Directed bench for gdma_arb: reset, single job, fairness, throttle, edge cases,
// backpressure and mid-job reset.
module tb_gdma_arb;

  localparam int NREQ = 8;
  localparam int AW   = 49;
  localparam int LW   = 32;

  logic               clk;
  logic               rst_n;
  logic [NREQ-1:0]    req_start;
  logic [NREQ*AW-1:0] req_addr;
  logic [NREQ*LW-1:0] req_len;
  logic [31:0]        speed_divider;
  logic               cmd_valid;
  logic               cmd_ready;
  logic [2:0]         cmd_id;
  logic [AW-1:0]      cmd_addr;
  logic [LW-1:0]      cmd_len;
  logic               eng_done;
  logic [NREQ-1:0]    req_done;
  logic [NREQ-1:0]    pending;
  logic               busy;

  int n_cmp = 0;
  int n_err = 0;

  gdma_arb #(.NREQ(NREQ), .AW(AW), .LW(LW)) dut (
    .gdma_clk      (clk),
    .gdma_rst_n    (rst_n),
    .req_start     (req_start),
    .req_addr      (req_addr),
    .req_len       (req_len),
    .speed_divider (speed_divider),
    .cmd_valid     (cmd_valid),
    .cmd_ready     (cmd_ready),
    .cmd_id        (cmd_id),
    .cmd_addr      (cmd_addr),
    .cmd_len       (cmd_len),
    .eng_done      (eng_done),
    .req_done      (req_done),
    .pending       (pending),
    .busy          (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic set_job(input int i, input logic [AW-1:0] a, input logic [LW-1:0] l);
    req_addr[i*AW +: AW] = a;
    req_len[i*LW +: LW]  = l;
  endtask

  task automatic do_reset();
    req_start = '0;
    eng_done  = 1'b0;
    cmd_ready = 1'b1;
    rst_n     = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    @(negedge clk);
  endtask

  // Waits for a command, accepts it (cmd_ready assumed high), pulses eng_done,
  // and returns the observed id and the req_done vector of the following cycle.
  task automatic serve(output logic [2:0] id, output logic [NREQ-1:0] done, output bit to);
    int t;
    t    = 0;
    to   = 1'b0;
    id   = 3'd0;
    done = '0;
    while (cmd_valid !== 1'b1 && t < 40) begin
      @(negedge clk);
      t++;
    end
    if (cmd_valid !== 1'b1) begin
      to = 1'b1;
      return;
    end
    id = cmd_id;
    @(negedge clk);
    eng_done = 1'b1;
    @(negedge clk);
    eng_done = 1'b0;
    done = req_done;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    @(negedge clk);
    @(negedge clk);
    n_cmp++;
    if (cmd_valid !== 1'b0 || busy !== 1'b0 || pending !== 8'h00 || req_done !== 8'h00 ||
        cmd_id !== 3'd0 || cmd_addr !== '0 || cmd_len !== '0) begin
      n_err++;
      $display("FAIL reset_state: valid=%b busy=%b pend=%h done=%h id=%0d addr=%h len=%h, required all zero",
               cmd_valid, busy, pending, req_done, cmd_id, cmd_addr, cmd_len);
    end
    rst_n = 1'b1;
    @(negedge clk);
    @(negedge clk);
  endtask

  task automatic test_single();
    set_job(2, 49'h1_0000_1000, 32'd256);
    req_start[2] = 1'b1;
    @(negedge clk);
    n_cmp++;
    if (pending !== 8'h04 || busy !== 1'b0 || cmd_valid !== 1'b0) begin
      n_err++;
      $display("FAIL single_pending: pend=%h busy=%b valid=%b, required 04 0 0", pending, busy, cmd_valid);
    end
    @(negedge clk);
    n_cmp++;
    if (cmd_valid !== 1'b1 || cmd_id !== 3'd2 || cmd_addr !== 49'h1_0000_1000 ||
        cmd_len !== 32'd256 || pending !== 8'h00 || busy !== 1'b1) begin
      n_err++;
      $display("FAIL single_issue: valid=%b id=%0d addr=%h len=%0d pend=%h busy=%b, required 1 2 100001000 256 00 1",
               cmd_valid, cmd_id, cmd_addr, cmd_len, pending, busy);
    end
    @(negedge clk);
    n_cmp++;
    if (cmd_valid !== 1'b0 || busy !== 1'b1) begin
      n_err++;
      $display("FAIL single_wait: valid=%b busy=%b, required 0 1", cmd_valid, busy);
    end
    eng_done = 1'b1;
    @(negedge clk);
    eng_done = 1'b0;
    n_cmp++;
    if (req_done !== 8'h04 || busy !== 1'b0) begin
      n_err++;
      $display("FAIL single_done: done=%h busy=%b, required 04 0", req_done, busy);
    end
    @(negedge clk);
    n_cmp++;
    if (req_done !== 8'h00) begin
      n_err++;
      $display("FAIL single_done_pulse: done=%h, required 00", req_done);
    end
    req_start[2] = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_fairness();
    logic [2:0]      id;
    logic [NREQ-1:0] done;
    bit              to;
    int              exp2 [2];
    do_reset();
    speed_divider = 32'd0;
    for (int i = 0; i < NREQ; i++) set_job(i, AW'(49'h100 * (i + 1)), 32'd16);
    req_start = 8'hFF;
    for (int k = 0; k < NREQ; k++) begin
      serve(id, done, to);
      n_cmp++;
      if (to || id !== 3'(k) || done !== (8'h01 << k)) begin
        n_err++;
        $display("FAIL fair_order_%0d: timeout=%0d id=%0d done=%h, required id %0d done %h",
                 k, to, id, done, k, 8'h01 << k);
      end
    end
    do_reset();
    req_start[5] = 1'b1;
    serve(id, done, to);
    req_start = '0;
    @(negedge clk);
    req_start[1] = 1'b1;
    req_start[6] = 1'b1;
    exp2[0] = 6;
    exp2[1] = 1;
    for (int k = 0; k < 2; k++) begin
      serve(id, done, to);
      n_cmp++;
      if (to || id !== 3'(exp2[k])) begin
        n_err++;
        $display("FAIL fair_wrap_%0d: timeout=%0d id=%0d, required %0d", k, to, id, exp2[k]);
      end
    end
    req_start = '0;
    @(negedge clk);
  endtask

  task automatic test_throttle();
    logic [2:0]      id;
    logic [NREQ-1:0] done;
    bit              to;
    int              gap;
    do_reset();
    speed_divider = 32'd4;
    set_job(0, 49'h0_0000_2000, 32'd8);
    set_job(3, 49'h0_0000_3000, 32'd8);
    req_start[0] = 1'b1;
    req_start[3] = 1'b1;
    serve(id, done, to);
    n_cmp++;
    if (to || id !== 3'd0 || done !== 8'h01) begin
      n_err++;
      $display("FAIL throttle_first: timeout=%0d id=%0d done=%h, required 0 01", to, id, done);
    end
    gap = 0;
    while (busy === 1'b1 && gap < 20) begin
      gap++;
      @(negedge clk);
    end
    n_cmp++;
    if (gap != 4) begin
      n_err++;
      $display("FAIL throttle_gap: gap cycles=%0d, required 4", gap);
    end
    @(negedge clk);
    n_cmp++;
    if (cmd_valid !== 1'b1 || cmd_id !== 3'd3) begin
      n_err++;
      $display("FAIL throttle_second: valid=%b id=%0d, required 1 3", cmd_valid, cmd_id);
    end
    serve(id, done, to);
    for (int i = 0; i < 6; i++) @(negedge clk);
    speed_divider = 32'd0;
    req_start = '0;
    @(negedge clk);
  endtask

  task automatic test_len_zero();
    do_reset();
    speed_divider = 32'd0;
    set_job(4, 49'h0_0000_4000, 32'd0);
    req_start[4] = 1'b1;
    @(negedge clk);
    n_cmp++;
    if (pending !== 8'h10 || cmd_valid !== 1'b0) begin
      n_err++;
      $display("FAIL len0_grant: pend=%h valid=%b, required 10 0", pending, cmd_valid);
    end
    @(negedge clk);
    n_cmp++;
    if (req_done !== 8'h10 || cmd_valid !== 1'b0 || busy !== 1'b0 || cmd_id !== 3'd4) begin
      n_err++;
      $display("FAIL len0_done: done=%h valid=%b busy=%b id=%0d, required 10 0 0 4",
               req_done, cmd_valid, busy, cmd_id);
    end
    @(negedge clk);
    n_cmp++;
    if (req_done !== 8'h00 || cmd_valid !== 1'b0) begin
      n_err++;
      $display("FAIL len0_after: done=%h valid=%b, required 00 0", req_done, cmd_valid);
    end
    req_start = '0;
    @(negedge clk);
  endtask

  task automatic test_rerise();
    logic [2:0]      id;
    logic [NREQ-1:0] done;
    bit              to;
    int              t;
    eng_done = 1'b1;
    @(negedge clk);
    eng_done = 1'b0;
    @(negedge clk);
    n_cmp++;
    if (req_done !== 8'h00 || busy !== 1'b0) begin
      n_err++;
      $display("FAIL stray_eng_done: done=%h busy=%b, required 00 0", req_done, busy);
    end
    set_job(1, 49'h0_0000_5000, 32'd8);
    req_start[1] = 1'b1;
    t = 0;
    while (cmd_valid !== 1'b1 && t < 20) begin
      @(negedge clk);
      t++;
    end
    @(negedge clk);
    req_start[1] = 1'b0;
    @(negedge clk);
    req_start[1] = 1'b1;
    @(negedge clk);
    n_cmp++;
    if (pending !== 8'h02 || busy !== 1'b1 || cmd_valid !== 1'b0) begin
      n_err++;
      $display("FAIL rerise_pending: pend=%h busy=%b valid=%b, required 02 1 0", pending, busy, cmd_valid);
    end
    eng_done = 1'b1;
    @(negedge clk);
    eng_done = 1'b0;
    n_cmp++;
    if (req_done !== 8'h02) begin
      n_err++;
      $display("FAIL rerise_done1: done=%h, required 02", req_done);
    end
    serve(id, done, to);
    n_cmp++;
    if (to || id !== 3'd1 || done !== 8'h02) begin
      n_err++;
      $display("FAIL rerise_second_run: timeout=%0d id=%0d done=%h, required 1 02", to, id, done);
    end
    req_start = '0;
    @(negedge clk);
  endtask

  task automatic test_backpressure_reset();
    logic [AW-1:0]   a_exp;
    logic [LW-1:0]   l_exp;
    logic [NREQ-1:0] acc_done;
    logic [NREQ-1:0] acc_pend;
    logic            acc_busy;
    bit              bad;
    int              t;
    a_exp = 49'h1_2345_6789_ABCD;
    l_exp = 32'h0000_1000;
    do_reset();
    cmd_ready = 1'b0;
    set_job(6, a_exp, l_exp);
    set_job(2, 49'h0_0000_7000, 32'd8);
    req_start[6] = 1'b1;
    t = 0;
    while (cmd_valid !== 1'b1 && t < 20) begin
      @(negedge clk);
      t++;
    end
    bad = 1'b0;
    for (int i = 0; i < 10; i++) begin
      if (cmd_valid !== 1'b1 || cmd_id !== 3'd6 || cmd_addr !== a_exp || cmd_len !== l_exp) bad = 1'b1;
      if (i == 3) begin
        set_job(6, 49'h0_0BAD_0000_0000, 32'd99);
        req_start[2] = 1'b1;
      end
      @(negedge clk);
    end
    n_cmp++;
    if (bad || cmd_valid !== 1'b1 || cmd_addr !== a_exp || cmd_len !== l_exp) begin
      n_err++;
      $display("FAIL backpressure_stable: valid=%b id=%0d addr=%h len=%h, required 1 6 %h %h",
               cmd_valid, cmd_id, cmd_addr, cmd_len, a_exp, l_exp);
    end
    cmd_ready = 1'b1;
    @(negedge clk);
    n_cmp++;
    if (cmd_valid !== 1'b0 || busy !== 1'b1 || pending !== 8'h04) begin
      n_err++;
      $display("FAIL backpressure_wait: valid=%b busy=%b pend=%h, required 0 1 04", cmd_valid, busy, pending);
    end
    rst_n = 1'b0;
    #1;
    n_cmp++;
    if (cmd_valid !== 1'b0 || busy !== 1'b0 || pending !== 8'h00 || req_done !== 8'h00 ||
        cmd_id !== 3'd0 || cmd_addr !== '0 || cmd_len !== '0) begin
      n_err++;
      $display("FAIL midjob_reset: valid=%b busy=%b pend=%h done=%h id=%0d addr=%h len=%h, required all zero",
               cmd_valid, busy, pending, req_done, cmd_id, cmd_addr, cmd_len);
    end
    @(negedge clk);
    rst_n = 1'b1;
    acc_done = '0;
    acc_pend = '0;
    acc_busy = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      acc_done = acc_done | req_done;
      acc_pend = acc_pend | pending;
      acc_busy = acc_busy | busy | cmd_valid;
    end
    n_cmp++;
    if (acc_done !== 8'h00 || acc_pend !== 8'h00 || acc_busy !== 1'b0) begin
      n_err++;
      $display("FAIL held_start_no_retrigger: done=%h pend=%h busy=%b, required 00 00 0",
               acc_done, acc_pend, acc_busy);
    end
    req_start[6] = 1'b0;
    @(negedge clk);
    req_start[6] = 1'b1;
    t = 0;
    while (cmd_valid !== 1'b1 && t < 20) begin
      @(negedge clk);
      t++;
    end
    n_cmp++;
    if (cmd_valid !== 1'b1 || cmd_id !== 3'd6 || cmd_addr !== 49'h0_0BAD_0000_0000 || cmd_len !== 32'd99) begin
      n_err++;
      $display("FAIL rearm_after_reset: valid=%b id=%0d addr=%h len=%0d, required 1 6 0bad00000000 99",
               cmd_valid, cmd_id, cmd_addr, cmd_len);
    end
    @(negedge clk);
    eng_done = 1'b1;
    @(negedge clk);
    eng_done = 1'b0;
    n_cmp++;
    if (req_done !== 8'h40) begin
      n_err++;
      $display("FAIL rearm_done: done=%h, required 40", req_done);
    end
    req_start = '0;
    @(negedge clk);
  endtask

  initial begin
    rst_n         = 1'b0;
    req_start     = '0;
    req_addr      = '0;
    req_len       = '0;
    speed_divider = 32'd0;
    cmd_ready     = 1'b1;
    eng_done      = 1'b0;
    test_reset();
    test_single();
    test_fairness();
    test_throttle();
    test_len_zero();
    test_rerise();
    test_backpressure_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
